// File: rtl/multi_sum_pipe.sv
// Pipelined adder-tree reduction of VALUE_COUNT unsigned values, one register per tree level
// plus a final saturate/truncate stage.
module multi_sum_pipe #(
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned VALUE_COUNT = 16,
    parameter int unsigned SUM_WIDTH   = 12,
    parameter int unsigned SATURATE    = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [VALUE_WIDTH*VALUE_COUNT-1:0] values,
    output logic                               out_valid,
    output logic [SUM_WIDTH-1:0]               sum,
    output logic                               overflow
);

    // Number of partial sums present at a given tree level.
    function automatic int unsigned nodes_at(input int unsigned level);
        int unsigned n;
        n = VALUE_COUNT;
        for (int unsigned l = 0; l < level; l++) n = (n + 1) / 2;
        return n;
    endfunction

    localparam int unsigned LEVELS = (VALUE_COUNT > 1) ? $clog2(VALUE_COUNT) : 0;
    localparam int unsigned FULL_W = VALUE_WIDTH + LEVELS;

    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned W = VALUE_WIDTH + k;
        localparam int unsigned N = nodes_at(k);

        logic [N*W-1:0] data;
        logic           valid;

        if (k == 0) begin : g_leaf
            assign data  = values;
            assign valid = in_valid;
        end else begin : g_add
            localparam int unsigned PW = W - 1;
            localparam int unsigned PN = nodes_at(k - 1);

            logic [N*W-1:0] next_c;

            // Pair adjacent partial sums; an odd leftover passes straight through.
            for (genvar i = 0; i < N; i++) begin : g_node
                if (2 * i + 1 < PN) begin : g_pair
                    assign next_c[i*W +: W] = W'(g_lvl[k-1].data[2*i*PW +: PW])
                                            + W'(g_lvl[k-1].data[(2*i+1)*PW +: PW]);
                end else begin : g_pass
                    assign next_c[i*W +: W] = W'(g_lvl[k-1].data[2*i*PW +: PW]);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid <= 1'b0;
                    data  <= '0;
                end else begin
                    valid <= g_lvl[k-1].valid;
                    if (g_lvl[k-1].valid) data <= next_c;
                end
            end
        end
    end

    logic [FULL_W-1:0]    full_c;
    logic [SUM_WIDTH-1:0] trunc_c;
    logic [SUM_WIDTH-1:0] sum_c;
    logic                 ovf_c;

    assign full_c = g_lvl[LEVELS].data;

    if (SUM_WIDTH >= FULL_W) begin : g_wide
        assign trunc_c = SUM_WIDTH'(full_c);
        assign ovf_c   = 1'b0;
    end else begin : g_narrow
        assign trunc_c = full_c[SUM_WIDTH-1:0];
        assign ovf_c   = |full_c[FULL_W-1:SUM_WIDTH];
    end

    assign sum_c = (ovf_c && SATURATE != 0) ? '1 : trunc_c;

    // Output stage holds the last result while no new beat arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= g_lvl[LEVELS].valid;
            if (g_lvl[LEVELS].valid) begin
                sum      <= sum_c;
                overflow <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_multi_sum_pipe.sv
// Bench for multi_sum_pipe: five parameter sets driven in lockstep, checked every cycle
// against a cycle-indexed history of hand-computed or reference expectations.
module tb_multi_sum_pipe;

    typedef struct packed {
        logic            iv;
        logic [4:0][2:0] v;
        logic [4:0][7:0] es;
        logic [4:0]      eo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [4:0][2:0] vals;

    logic [11:0] vals_a;
    logic [14:0] vals_d;
    logic [2:0]  vals_e;
    assign vals_a = vals[3:0];
    assign vals_d = vals;
    assign vals_e = vals[0];

    logic       vld_a, vld_b, vld_c, vld_d, vld_e;
    logic       ov_a, ov_b, ov_c, ov_d, ov_e;
    logic [4:0] sum_a;
    logic [3:0] sum_b, sum_c;
    logic [5:0] sum_d;
    logic [2:0] sum_e;

    multi_sum_pipe #(.VALUE_WIDTH(3), .VALUE_COUNT(4), .SUM_WIDTH(5), .SATURATE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .values(vals_a),
        .out_valid(vld_a), .sum(sum_a), .overflow(ov_a));
    multi_sum_pipe #(.VALUE_WIDTH(3), .VALUE_COUNT(4), .SUM_WIDTH(4), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .values(vals_a),
        .out_valid(vld_b), .sum(sum_b), .overflow(ov_b));
    multi_sum_pipe #(.VALUE_WIDTH(3), .VALUE_COUNT(4), .SUM_WIDTH(4), .SATURATE(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .values(vals_a),
        .out_valid(vld_c), .sum(sum_c), .overflow(ov_c));
    multi_sum_pipe #(.VALUE_WIDTH(3), .VALUE_COUNT(5), .SUM_WIDTH(6), .SATURATE(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .values(vals_d),
        .out_valid(vld_d), .sum(sum_d), .overflow(ov_d));
    multi_sum_pipe #(.VALUE_WIDTH(3), .VALUE_COUNT(1), .SUM_WIDTH(3), .SATURATE(1)) u_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .values(vals_e),
        .out_valid(vld_e), .sum(sum_e), .overflow(ov_e));

    logic [7:0] so [5];
    logic       vo [5];
    logic       oo [5];
    assign so[0] = 8'(sum_a); assign vo[0] = vld_a; assign oo[0] = ov_a;
    assign so[1] = 8'(sum_b); assign vo[1] = vld_b; assign oo[1] = ov_b;
    assign so[2] = 8'(sum_c); assign vo[2] = vld_c; assign oo[2] = ov_c;
    assign so[3] = 8'(sum_d); assign vo[3] = vld_d; assign oo[3] = ov_d;
    assign so[4] = 8'(sum_e); assign vo[4] = vld_e; assign oo[4] = ov_e;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int flush = 0;

    logic            hv  [2048];
    logic [4:0][7:0] hes [2048];
    logic [4:0]      heo [2048];
    logic [7:0]      hs  [5];
    logic            ho  [5];

    vec_t tbl [12];

    function automatic int lat(input int i);
        case (i)
            3:       return 4;
            4:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic vec_t row(input logic iv, input int v0, input int v1, input int v2,
                                 input int v3, input int v4, input int sa, input int oa,
                                 input int sb, input int ob, input int sc, input int oc,
                                 input int sd, input int se);
        vec_t r;
        r.iv    = iv;
        r.v[0]  = 3'(v0); r.v[1] = 3'(v1); r.v[2] = 3'(v2); r.v[3] = 3'(v3); r.v[4] = 3'(v4);
        r.es[0] = 8'(sa); r.es[1] = 8'(sb); r.es[2] = 8'(sc); r.es[3] = 8'(sd); r.es[4] = 8'(se);
        r.eo    = {1'b0, 1'b0, 1'(oc), 1'(ob), 1'(oa)};
        return r;
    endfunction

    // Reference: full-precision sum, then clamp or wrap into sw bits.
    function automatic logic [8:0] ref_out(input logic [4:0][2:0] v, input int n,
                                           input int sw, input bit sat);
        int full;
        int maxv;
        full = 0;
        for (int j = 0; j < n; j++) full += int'(v[j]);
        maxv = (1 << sw) - 1;
        if (full > maxv) return {1'b1, sat ? 8'(maxv) : 8'(full & maxv)};
        return {1'b0, 8'(full)};
    endfunction

    task automatic cmp(input string name, input int i, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, i, cyc, got, want);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 5; i++) begin
            int   n;
            logic ev;
            n  = cyc - lat(i);
            ev = 1'b0;
            if (n >= flush && n >= 0) ev = hv[n];
            if (ev) begin
                hs[i] = hes[n][i];
                ho[i] = heo[n][i];
            end
            cmp("out_valid", i, int'(vo[i]), int'(ev));
            cmp("sum",       i, int'(so[i]), int'(hs[i]));
            cmp("overflow",  i, int'(oo[i]), int'(ho[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 5; i++) begin
            cmp({tag, "_valid"}, i, int'(vo[i]), 0);
            cmp({tag, "_sum"},   i, int'(so[i]), 0);
            cmp({tag, "_ovf"},   i, int'(oo[i]), 0);
        end
    endtask

    task automatic step(input vec_t r);
        in_valid = r.iv;
        vals     = r.v;
        hv[cyc]  = r.iv;
        hes[cyc] = r.es;
        heo[cyc] = r.eo;
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic clear_hold();
        for (int i = 0; i < 5; i++) begin
            hs[i] = 8'd0;
            ho[i] = 1'b0;
        end
    endtask

    initial begin
        vec_t idle;
        vec_t r;
        logic [8:0] t;

        idle = '0;
        for (int i = 0; i < 2048; i++) hv[i] = 1'b0;
        clear_hold();

        tbl[0]  = row(1, 0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0);
        tbl[1]  = row(1, 2, 0, 2, 0, 0,  4, 0,  4, 0,  4, 0,  4, 2);
        tbl[2]  = row(1, 2, 2, 2, 2, 0,  8, 0,  8, 0,  8, 0,  8, 2);
        tbl[3]  = row(1, 7, 7, 7, 0, 0, 21, 0, 15, 1,  5, 1, 21, 7);
        tbl[4]  = row(1, 7, 6, 5, 4, 0, 22, 0, 15, 1,  6, 1, 22, 7);
        tbl[5]  = row(1, 7, 7, 1, 0, 0, 15, 0, 15, 0, 15, 0, 15, 7);
        tbl[6]  = row(1, 1, 2, 3, 4, 5, 10, 0, 10, 0, 10, 0, 15, 1);
        tbl[7]  = row(1, 6, 0, 0, 0, 0,  6, 0,  6, 0,  6, 0,  6, 6);
        tbl[8]  = row(0, 7, 7, 7, 7, 7,  0, 0,  0, 0,  0, 0,  0, 0);
        tbl[9]  = row(1, 4, 5, 0, 0, 0,  9, 0,  9, 0,  9, 0,  9, 4);
        tbl[10] = row(0, 3, 3, 3, 3, 3,  0, 0,  0, 0,  0, 0,  0, 0);
        tbl[11] = row(1, 6, 7, 0, 0, 0, 13, 0, 13, 0, 13, 0, 13, 6);

        rst      = 1'b1;
        in_valid = 1'b0;
        vals     = '0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        flush = cyc;

        // Directed beats back-to-back, including the 1,0,1 gap pattern at the end.
        for (int k = 0; k < 12; k++) step(tbl[k]);
        repeat (5) step(idle);

        // Asynchronous reset mid-cycle with beats still in flight.
        step(tbl[3]);
        step(tbl[4]);
        step(tbl[5]);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_zero("async_rst");
        repeat (2) begin
            hv[cyc] = 1'b0;
            @(posedge clk);
            cyc++;
        end
        #3 rst = 1'b0;
        flush = cyc;
        clear_hold();
        repeat (6) step(idle);

        // Beat on the first edge after release, then random beats every cycle.
        step(tbl[4]);
        for (int k = 0; k < 1000; k++) begin
            r    = '0;
            r.iv = 1'b1;
            for (int j = 0; j < 5; j++) r.v[j] = 3'($urandom_range(0, 7));
            for (int i = 0; i < 5; i++) begin
                case (i)
                    0:       t = ref_out(r.v, 4, 5, 1'b1);
                    1:       t = ref_out(r.v, 4, 4, 1'b1);
                    2:       t = ref_out(r.v, 4, 4, 1'b0);
                    3:       t = ref_out(r.v, 5, 6, 1'b1);
                    default: t = ref_out(r.v, 1, 3, 1'b1);
                endcase
                r.es[i] = t[7:0];
                r.eo[i] = t[8];
            end
            step(r);
        end
        repeat (5) step(idle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
